// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue/writeback stage: funct codes, ALU ops,
// FSM states and the funct decoder.
package alu_issue_pkg;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
  } decode_t;

  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d.legal = 1'b1;
    d.op    = OP_AND;
    case (funct)
      FUNCT_AND: d.op = OP_AND;
      FUNCT_OR:  d.op = OP_OR;
      FUNCT_ADD: d.op = OP_ADD;
      FUNCT_SUB: d.op = OP_SUB;
      FUNCT_SLT: d.op = OP_SLT;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// 2^AW x DW register file: two operand read ports, one debug read port and a
// single synchronous write port. r0 reads as zero and ignores writes.
module alu_regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_rd_addr_a,
  output logic [DW-1:0] o_rd_data_a,
  input  logic [AW-1:0] i_rd_addr_b,
  output logic [DW-1:0] o_rd_data_b,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_dbg_data,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wr_addr != '0)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_mem[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_mem[i_rd_addr_b];
  assign o_dbg_data  = (i_dbg_addr  == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage feeding a combinational 32-bit ALU: decodes R-type
// instructions, drives registered operands and writes the result back.
//
// state | meaning
// IDLE  | accept an instruction or a direct register load
// EXEC  | operands on the ALU; capture its result at the end of the cycle
// WB    | wb_valid pulse; write the captured result unless rd==0 or overflow
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  input  logic          alu_over,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          wb_zero,
  output logic          wb_over,
  output logic          err_illegal,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        r_state, w_state_next;
  logic [DW-1:0] r_alu_a, r_alu_b;
  logic [2:0]    r_alu_op;
  logic [AW-1:0] r_rd, r_wb_rd;
  logic [DW-1:0] r_wb_data;
  logic          r_wb_zero, r_wb_over, r_wb_valid, r_err_illegal;

  logic [AW-1:0] w_rs, w_rt, w_rd;
  logic [DW-1:0] w_rs_data, w_rt_data;
  decode_t       w_dec;
  logic          w_accept;
  logic          w_rf_we;
  logic [AW-1:0] w_rf_waddr;
  logic [DW-1:0] w_rf_wdata;
  logic          w_unused_instr;

  assign w_rs  = AW'(in_instr[25:21]);
  assign w_rt  = AW'(in_instr[20:16]);
  assign w_rd  = AW'(in_instr[15:11]);
  assign w_dec = decode_funct(in_instr[5:0]);
  assign w_unused_instr = &{in_instr[31:26], in_instr[10:6]};

  assign in_ready = (r_state == IDLE) && !ld_valid;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && w_dec.legal) w_state_next = EXEC;
      EXEC:    w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Loads only happen in IDLE and writebacks only in WB, so they never collide.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = '0;
    w_rf_wdata = '0;
    if ((r_state == IDLE) && ld_valid) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = ld_addr;
      w_rf_wdata = ld_data;
    end else if ((r_state == WB) && !r_wb_over) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = r_wb_rd;
      w_rf_wdata = r_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= OP_AND;
      r_rd          <= '0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
      r_wb_zero     <= 1'b0;
      r_wb_over     <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      r_wb_valid    <= (r_state == EXEC);
      r_err_illegal <= w_accept && !w_dec.legal;
      if (w_accept && w_dec.legal) begin
        r_alu_a  <= w_rs_data;
        r_alu_b  <= w_rt_data;
        r_alu_op <= w_dec.op;
        r_rd     <= w_rd;
      end
      if (r_state == EXEC) begin
        r_wb_data <= alu_out;
        r_wb_zero <= alu_zero;
        r_wb_over <= alu_over && ((r_alu_op == OP_ADD) || (r_alu_op == OP_SUB));
        r_wb_rd   <= r_rd;
      end
    end
  end

  alu_regfile #(.DW(DW), .AW(AW)) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_addr_a (w_rs),
    .o_rd_data_a (w_rs_data),
    .i_rd_addr_b (w_rt),
    .o_rd_data_b (w_rt_data),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_data  (dbg_data),
    .i_we        (w_rf_we),
    .i_wr_addr   (w_rf_waddr),
    .i_wr_data   (w_rf_wdata)
  );

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign wb_zero     = r_wb_zero;
  assign wb_over     = r_wb_over;
  assign err_illegal = r_err_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, register-file model and a
// writeback scoreboard, plus directed scenario tasks.
module tb_alu_issue_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_out;
  logic          alu_zero, alu_over;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_zero, wb_over;
  logic          err_illegal;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic force_over = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        over;
    logic        zero;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rf_model [32];

  alu_issue_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_over(alu_over),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_zero(wb_zero), .wb_over(wb_over), .err_illegal(err_illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream ALU; force_over lets a test drive
  // the overflow flag high on ops where it must be ignored.
  logic [32:0] wide;
  always_comb begin
    wide    = '0;
    alu_out = '0;
    case (alu_op)
      3'd0: alu_out = alu_a & alu_b;
      3'd1: alu_out = alu_a | alu_b;
      3'd2: begin wide = {alu_a[31], alu_a} + {alu_b[31], alu_b}; alu_out = wide[31:0]; end
      3'd6: begin wide = {alu_a[31], alu_a} - {alu_b[31], alu_b}; alu_out = wide[31:0]; end
      3'd3: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == 32'd0);
    alu_over = force_over | (((alu_op == 3'd2) || (alu_op == 3'd6)) && (wide[32] != wide[31]));
  end

  function automatic logic legal_funct(input logic [5:0] f);
    return (f == 6'h24) || (f == 6'h25) || (f == 6'h20) || (f == 6'h22) || (f == 6'h2A);
  endfunction

  function automatic exp_t predict(input logic [31:0] instr);
    exp_t        e;
    logic [31:0] a, b, d;
    logic        ov;
    a  = rf_model[instr[25:21]];
    b  = rf_model[instr[20:16]];
    d  = 32'd0;
    ov = 1'b0;
    case (instr[5:0])
      6'h24: d = a & b;
      6'h25: d = a | b;
      6'h20: begin d = a + b; ov = (a[31] == b[31]) && (d[31] != a[31]); end
      6'h22: begin d = a - b; ov = (a[31] != b[31]) && (d[31] != a[31]); end
      6'h2A: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: d = 32'd0;
    endcase
    e.rd   = instr[15:11];
    e.data = d;
    e.over = ov;
    e.zero = (d == 32'd0);
    return e;
  endfunction

  // Scoreboard: every writeback pulse must match the oldest predicted result.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_wb: got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({wb_rd, wb_data, wb_over, wb_zero} !== {e.rd, e.data, e.over, e.zero}) begin
          errors++;
          $display("FAIL sb_wb: got rd=%0d data=%h over=%b zero=%b, required rd=%0d data=%h over=%b zero=%b",
                   wb_rd, wb_data, wb_over, wb_zero, e.rd, e.data, e.over, e.zero);
        end
        if (!e.over && (e.rd != 5'd0)) rf_model[e.rd] = e.data;
      end
    end
  end

  task automatic load(input logic [4:0] addr, input logic [31:0] data);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    @(negedge clk);
    ld_valid = 1'b0;
    if (addr != 5'd0) rf_model[addr] = data;
  endtask

  // Caller is at a negedge with the stage in IDLE; returns one edge after accept.
  task automatic issue(input logic [31:0] instr);
    if (legal_funct(instr[5:0])) sb_q.push_back(predict(instr));
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; ld_valid = 1'b0;
    ld_addr = '0; ld_data = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_valid, err_illegal, wb_over, wb_zero} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {wb_valid, err_illegal, wb_over, wb_zero});
    end
    checks++;
    if ({alu_a, alu_b, alu_op, wb_data, wb_rd} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got a=%h b=%h op=%0d data=%h rd=%0d, required all 0", alu_a, alu_b, alu_op, wb_data, wb_rd);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_add();
    int cnt;
    bit found;
    load(5'd1, 32'd25);
    load(5'd2, 32'd23);
    issue(32'h00221820);
    cnt = 1; found = 1'b0;
    while (!found && cnt < 6) begin
      if (wb_valid) found = 1'b1;
      else begin @(negedge clk); cnt++; end
    end
    checks++;
    if (!found || cnt != 2) begin
      errors++;
      $display("FAIL add_latency: got found=%0d edges=%0d, required found=1 edges=2", found, cnt);
    end
    checks++;
    if ({wb_rd, wb_data, wb_over} !== {5'd3, 32'd48, 1'b0}) begin
      errors++;
      $display("FAIL add_wb: got rd=%0d data=%0d over=%b, required rd=3 data=48 over=0", wb_rd, wb_data, wb_over);
    end
    @(negedge clk);
    dbg_addr = 5'd3; #1;
    checks++;
    if (wb_valid !== 1'b0 || dbg_data !== 32'd48) begin
      errors++;
      $display("FAIL add_dbg: got wb_valid=%b r3=%0d, required wb_valid=0 r3=48", wb_valid, dbg_data);
    end
  endtask

  task automatic test_sub();
    load(5'd1, 32'd555);
    load(5'd2, 32'd5);
    issue(32'h00221822);
    checks++;
    if (alu_op !== 3'd6 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL sub_exec: got op=%0d ready=%b, required op=6 ready=0", alu_op, in_ready);
    end
    @(negedge clk);
    checks++;
    if (wb_data !== 32'd550 || in_ready !== 1'b0 || alu_op !== 3'd6) begin
      errors++;
      $display("FAIL sub_wb: got data=%0d ready=%b op=%0d, required data=550 ready=0 op=6", wb_data, in_ready, alu_op);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL sub_ready_back: got %b, required 1", in_ready); end
  endtask

  task automatic test_overflow();
    load(5'd1, 32'h7FFF_FFFF);
    load(5'd2, 32'd1);
    load(5'd3, 32'd7);
    issue(32'h00221820);
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_over} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_wb: got valid=%b over=%b, required 11", wb_valid, wb_over);
    end
    @(negedge clk);
    dbg_addr = 5'd3; #1;
    checks++;
    if (dbg_data !== 32'd7) begin errors++; $display("FAIL ovf_suppress: got r3=%h, required 7", dbg_data); end
    load(5'd1, 32'd1);
    load(5'd2, 32'd23);
    force_over = 1'b1;
    issue(32'h0022202A);
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_over, wb_data} !== {1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL slt_wb: got valid=%b over=%b data=%0d, required valid=1 over=0 data=1", wb_valid, wb_over, wb_data);
    end
    force_over = 1'b0;
    @(negedge clk);
    dbg_addr = 5'd4; #1;
    checks++;
    if (dbg_data !== 32'd1) begin errors++; $display("FAIL slt_r4: got %h, required 1", dbg_data); end
  endtask

  task automatic test_illegal_and_r0();
    issue(32'h00221818);
    checks++;
    if ({err_illegal, in_ready, wb_valid} !== 3'b110) begin
      errors++;
      $display("FAIL illegal_pulse: got err=%b ready=%b wb=%b, required 110", err_illegal, in_ready, wb_valid);
    end
    @(negedge clk);
    dbg_addr = 5'd3; #1;
    checks++;
    if (err_illegal !== 1'b0 || wb_valid !== 1'b0 || dbg_data !== 32'd7) begin
      errors++;
      $display("FAIL illegal_after: got err=%b wb=%b r3=%h, required err=0 wb=0 r3=7", err_illegal, wb_valid, dbg_data);
    end
    issue(32'h00220024);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd0) begin
      errors++;
      $display("FAIL and_r0_wb: got valid=%b rd=%0d, required valid=1 rd=0", wb_valid, wb_rd);
    end
    @(negedge clk);
    dbg_addr = 5'd0; #1;
    checks++;
    if (dbg_data !== 32'd0) begin errors++; $display("FAIL r0_zero: got %h, required 0", dbg_data); end
  endtask

  task automatic test_load_priority();
    ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'h0000_1234;
    in_valid = 1'b1; in_instr = 32'h00223020;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ldpri_ready: got %b, required 0", in_ready); end
    @(negedge clk);
    ld_valid = 1'b0; in_valid = 1'b0;
    rf_model[5] = 32'h0000_1234;
    repeat (3) @(negedge clk);
    dbg_addr = 5'd5; #1;
    checks++;
    if (dbg_data !== 32'h0000_1234 || in_ready !== 1'b1 || alu_op !== 3'd0) begin
      errors++;
      $display("FAIL ldpri_result: got r5=%h ready=%b op=%0d, required r5=1234 ready=1 op=0", dbg_data, in_ready, alu_op);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] functs [5];
    functs[0] = 6'h24; functs[1] = 6'h25; functs[2] = 6'h20; functs[3] = 6'h22; functs[4] = 6'h2A;
    for (int r = 1; r < 8; r++) load(5'(r), $urandom());
    load(5'd6, 32'h8000_0000);
    for (int i = 0; i < 12; i++) begin
      logic [31:0] instr;
      instr = 32'd0;
      instr[25:21] = 5'($urandom_range(0, 7));
      instr[20:16] = 5'($urandom_range(0, 7));
      instr[15:11] = 5'($urandom_range(0, 7));
      instr[5:0]   = functs[$urandom_range(0, 4)];
      issue(instr);
      repeat (2) @(negedge clk);
    end
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 5'(r); #1;
      checks++;
      if (dbg_data !== rf_model[r]) begin
        errors++;
        $display("FAIL b2b_rf r%0d: got %h, required %h", r, dbg_data, rf_model[r]);
      end
    end
  endtask

  task automatic test_mid_reset();
    load(5'd1, 32'd10);
    load(5'd2, 32'd20);
    issue(32'h00221820);
    rst_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    @(negedge clk);
    checks++;
    if ({wb_valid, alu_op} !== 4'b0000 || alu_a !== 32'd0 || alu_b !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: got wb=%b op=%0d a=%h b=%h ready=%b, required wb=0 op=0 a=0 b=0 ready=1",
               wb_valid, alu_op, alu_a, alu_b, in_ready);
    end
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r); #1;
      checks++;
      if (dbg_data !== 32'd0) begin errors++; $display("FAIL midrst_rf r%0d: got %h, required 0", r, dbg_data); end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_illegal_and_r0();
    test_load_priority();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending writebacks, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
